fp32_mul_seq: RTL
=================

// Module: fp32_mul_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision multiply sequencer with valid/ready handshakes on both sides.
//  Accepts one operand pair, screens special cases, then runs the 24x24 mantissa product by iterative shift-add.
//  Normalises, rounds and packs the result, and reports exception status in place of a status string.
//  Sits between the operand issue logic and the result writeback, replacing the combinational product/normaliser pair.
// PARAMETERS
//  STEPS     1  multiplier bits consumed per MUL cycle; legal values 1,2,3,4,6,8,12,24; MUL lasts 24/STEPS cycles
//  RND_MODE  1  0 = truncate, 1 = round-to-nearest-even
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   sequencer idle, can accept operands
//  a          in   32  operand A, fp32
//  b          in   32  operand B, fp32
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  fp32 product
//  status     out  3   [0] invalid, [1] overflow, [2] underflow
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, result=0, status=0, counter/accumulator cleared.
//  FSM states: IDLE -> CHECK -> MUL -> NORM -> DONE -> IDLE. A special-case result goes CHECK -> DONE directly.
//  IDLE: in_ready=1. in_valid&&in_ready at an edge latches a,b and moves to CHECK. in_ready=0 in every other state.
//  CHECK (1 cycle): sign = a[31]^b[31]. Exponent 0 is treated as zero; denormals are flushed to zero.
//   - either operand NaN (exp FF, mant!=0) -> 32'h7FC00000, status=001.
//   - inf x zero -> 32'h7FC00000, status=001.
//   - inf x (nonzero or inf) -> {sign,8'hFF,23'h0}, status=000.
//   - zero x finite -> {sign,31'h0}, status=000.
//   - otherwise: load {1,mant} for both operands, clear the 48b accumulator, count=0, exp_sum = ea+eb-127
//     (10b signed), then go to MUL.
//  MUL: each cycle adds the shifted multiplicand for the next STEPS multiplier bits.
//   count increments by STEPS; leave MUL when count reaches 24. Result is the exact 48b product.
//  NORM (1 cycle):
//   - if prod[47]=1: mant = prod[46:24], exp_sum += 1; else mant = prod[45:23].
//   - guard = next lower bit; sticky = OR of the remaining bits.
//   - RNE: increment if guard && (sticky || lsb). A mantissa carry-out sets mant=0 and exp_sum += 1.
//   - exp_sum >= 255 -> {sign,8'hFF,23'h0}, status=010.
//   - exp_sum <= 0 -> {sign,31'h0}, status=100; no gradual underflow.
//   - else pack {sign, exp_sum[7:0], mant}, status=000.
//  DONE: out_valid=1. result and status are held stable until out_valid&&out_ready at an edge, then go to IDLE.
//   No new operand is accepted in the same cycle.
//  Latency, accept edge to out_valid high:
//   - normal operands: 3 + 24/STEPS cycles (27 with STEPS=1).
//   - special cases: 2 cycles.
//   - throughput: one result per latency+1 cycles with out_ready held high.
//  in_valid while busy is ignored; the source must hold it until in_ready.
//  a and b are sampled only at the accept edge; later changes have no effect.
//  rst asserted in any state aborts the operation. The partial result is discarded, never emitted.
// TESTING
//  3F800000 x 40000000 -> result 40000000, status 000, out_valid exactly 27 cycles after accept (STEPS=1).
//  BE99999A x 43FA0000 (-0.3 x 500) -> C3160000, status 000.
//  BF800000 x 3F800001, RND_MODE=1 -> BF800001; repeat with RND_MODE=0 -> same.
//  3FFFFFFF x 3FFFFFFF -> 407FFFFE with RND_MODE=1, 407FFFFE truncated.
//  7F7FFFFF x 40000000 -> 7F800000, status 010.
//  7F800000 x 00000000 -> 7FC00000, status 001, out_valid 2 cycles after accept.
//  00800000 x 3F000000 -> 00000000, status 100.
//  80000000 x 40400000 -> 80000000, status 000.
//  out_ready low for 5 cycles in DONE:
//   - result and status hold stable, in_ready stays 0.
//   - out_ready high -> IDLE on the next edge, then in_ready=1.
//  Assert rst mid-MUL (cycle 10):
//   - out_valid=0 and in_ready=1 immediately.
//   - the next operand pair completes correctly, with no stale data.
//  Back-to-back 100 random normal pairs with STEPS=1,4,24:
//   - bit-exact against a shortreal reference with RNE and flush-to-zero.

Source files
------------

// File: rtl/fp32_mul_seq.sv
// ---------------------------------------------------------------------------
// fp32_mul_seq
// Multi-cycle IEEE-754 single-precision multiplier with valid/ready handshakes
// on both sides. One operand pair is accepted, special operands are screened,
// the 24x24 mantissa product is built by iterative shift-add, and the result
// is normalised, rounded and packed. Exceptions are reported on status.
//
// Denormal inputs are flushed to zero and results that would be denormal are
// flushed to zero (no gradual underflow).
//
// Parameters
//   STEPS     multiplier bits consumed per MUL cycle (1,2,3,4,6,8,12,24);
//             the MUL phase lasts 24/STEPS cycles
//   RND_MODE  0 = truncate, 1 = round-to-nearest-even
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   sequencer idle, operands accepted on in_valid && in_ready
//   a, b       fp32 operands, sampled only at the accept edge
//   out_valid  result valid, held until out_valid && out_ready
//   out_ready  consumer accepts the result
//   result     fp32 product
//   status     [0] invalid, [1] overflow, [2] underflow
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for an operand pair, in_ready high
// CHECK  | screen NaN/inf/zero, load mantissas and biased exponent sum
// MUL    | shift-add STEPS multiplier bits per cycle into the accumulator
// NORM   | normalise, round, detect overflow/underflow, pack result
// DONE   | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fp32_mul_seq #(
  parameter int STEPS    = 1,
  parameter int RND_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [2:0]         state;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [47:0]        mcand;
  logic [23:0]        mplr;
  logic [47:0]        acc;
  logic [4:0]         count;
  logic signed [9:0]  exp_sum;

  // -------------------------------------------------------------------------
  // Operand classification (from the latched operands)
  // -------------------------------------------------------------------------
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] ma;
  logic [22:0] mb;
  logic        sign;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;

  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    ma     = op_a[22:0];
    mb     = op_b[22:0];
    sign   = op_a[31] ^ op_b[31];
    a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    // exponent 0 covers both true zero and denormals, which are flushed
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
  end

  // -------------------------------------------------------------------------
  // Shift-add step: consume the low STEPS bits of the multiplier. The
  // multiplicand register is pre-shifted so bit i here weighs 2^(count+i).
  // -------------------------------------------------------------------------
  logic [47:0] step_sum;

  always_comb begin
    step_sum = acc;
    for (int i = 0; i < STEPS; i++) begin
      if (mplr[i]) begin
        step_sum = step_sum + (mcand << i);
      end
    end
  end

  logic [4:0] count_next;
  assign count_next = count + 5'(STEPS);

  // -------------------------------------------------------------------------
  // Normalise and round. The product of two [1,2) mantissas lies in [1,4),
  // so at most one right shift is needed before rounding.
  // -------------------------------------------------------------------------
  logic              prod_hi;
  logic [22:0]       mant_pre;
  logic              guard;
  logic              sticky;
  logic              rnd_inc;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_adj;
  logic signed [9:0] exp_fin;
  logic              ovf;
  logic              unf;

  always_comb begin
    prod_hi  = acc[47];
    mant_pre = prod_hi ? acc[46:24] : acc[45:23];
    guard    = prod_hi ? acc[23]    : acc[22];
    sticky   = prod_hi ? (|acc[22:0]) : (|acc[21:0]);
    exp_adj  = exp_sum + (prod_hi ? 10'sd1 : 10'sd0);
    rnd_inc  = (RND_MODE != 0) && guard && (sticky || mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + {23'd0, rnd_inc};
    // carry out of the rounded mantissa leaves mant_rnd[22:0] == 0
    exp_fin  = exp_adj + (mant_rnd[23] ? 10'sd1 : 10'sd0);
    ovf      = (exp_fin >= 10'sd255);
    unf      = (exp_fin <= 10'sd0);
  end

  // -------------------------------------------------------------------------
  // Handshake outputs decode directly from the state register
  // -------------------------------------------------------------------------
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      mcand   <= 48'd0;
      mplr    <= 24'd0;
      acc     <= 48'd0;
      count   <= 5'd0;
      exp_sum <= 10'sd0;
      result  <= 32'd0;
      status  <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result <= QNAN;
            status <= 3'b001;
            state  <= S_DONE;
          end else if (a_inf || b_inf) begin
            result <= {sign, 8'hFF, 23'd0};
            status <= 3'b000;
            state  <= S_DONE;
          end else if (a_zero || b_zero) begin
            result <= {sign, 31'd0};
            status <= 3'b000;
            state  <= S_DONE;
          end else begin
            mcand   <= {24'd0, 1'b1, ma};
            mplr    <= {1'b1, mb};
            acc     <= 48'd0;
            count   <= 5'd0;
            exp_sum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
            state   <= S_MUL;
          end
        end

        S_MUL: begin
          acc   <= step_sum;
          mcand <= mcand << STEPS;
          mplr  <= mplr >> STEPS;
          count <= count_next;
          if (count_next == 5'd24) begin
            state <= S_NORM;
          end
        end

        S_NORM: begin
          if (ovf) begin
            result <= {sign, 8'hFF, 23'd0};
            status <= 3'b010;
          end else if (unf) begin
            result <= {sign, 31'd0};
            status <= 3'b100;
          end else begin
            result <= {sign, exp_fin[7:0], mant_rnd[22:0]};
            status <= 3'b000;
          end
          state <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
